uart_tx_burst: RTL and testbench
================================

UART_TX_BURST -- requirements
Module: uart_tx_burst

Interface
REQ-001 SHALL have parameter BAUD_PRESCALER, default 200, clocks per bit (250000 baud at 50 MHz); legal range 2..65535.
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per character; legal range 5..9.
REQ-003 SHALL have parameter WORDS, default 4, characters per burst; legal range 1..16.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits per character; legal range 1..2.
REQ-005 SHALL have parameter PARITY_ODD, default 0, parity sense: 0 = even, 1 = odd.
REQ-006 SHALL have port i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 SHALL have port i_rst  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port i_data  input  WORDS*DATA_BITS  burst payload; character k = i_data[k*DATA_BITS +: DATA_BITS].
REQ-009 SHALL have port i_valid  input  1  payload present.
REQ-010 SHALL have port o_ready  output  1  high only in IDLE; a load occurs on a cycle with i_valid & o_ready.
REQ-011 SHALL have port o_busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port o_done  output  1  single-cycle pulse at burst completion.
REQ-013 SHALL have port o_tx  output  1  serial line, idle high.

Function
REQ-014 SHALL capture all of i_data into an internal register on load; later i_data changes SHALL NOT affect the burst in flight.
REQ-015 SHALL use states IDLE, START, DATA, PARITY, STOP; IDLE->START on load; START->DATA; DATA->PARITY after DATA_BITS bits (PARITY only when compiled in, else DATA->STOP); STOP->START if characters remain, else STOP->IDLE.
REQ-016 SHALL drive o_tx low starting the cycle after load (1-cycle latency); every bit, including each stop bit, lasts exactly BAUD_PRESCALER clocks.
REQ-017 SHALL restart the baud counter at 0 on load; the counter SHALL NOT run in IDLE.
REQ-018 SHALL send characters in order k = 0..WORDS-1, each LSB first, o_tx = 0 for start and 1 for stop.
REQ-019 SHALL drive o_tx high in IDLE and STOP.
REQ-020 SHALL assert o_done for exactly one cycle, the first IDLE cycle after the final stop bit.
REQ-021 SHALL accept a new load in that same first-IDLE cycle (o_ready = 1), giving back-to-back bursts a final stop bit of BAUD_PRESCALER+1 clocks.
REQ-022 SHALL ignore i_valid while o_busy; no queuing.
REQ-023 SHALL send WORDS*(1+DATA_BITS+P+STOP_BITS)*BAUD_PRESCALER clocks of frame per burst, P = 1 with parity else 0.

Reset
REQ-024 SHALL, on i_rst asserted at any time including mid-character, go to IDLE immediately with o_tx = 1, o_ready = 1, o_busy = 0, o_done = 0 and counters cleared.
REQ-025 SHALL NOT emit o_done for a burst aborted by reset.

Configuration
REQ-026 SHALL, with macro UART_TX_BURST_PARITY_EN defined, insert one parity bit after the data bits of every character: even parity (XOR of data bits) when PARITY_ODD = 0, inverted when 1.
REQ-027 SHALL, without UART_TX_BURST_PARITY_EN, have no PARITY state, ignore PARITY_ODD and send no parity bit.

Structure
REQ-028 SHALL take the state encoding type and the idle line level constant from shared package uart_pkg.
REQ-029 SHALL place the baud counter in sub-module uart_baud_tick (parameter BAUD_PRESCALER; ports i_clk, i_rst, i_run, o_tick), o_tick high one cycle per bit period.

Verification (BAUD_PRESCALER=4, DATA_BITS=8, WORDS=2, STOP_BITS=1 unless stated)
REQ-030 SHALL cover: load 16'h3CA5, no parity -> o_tx bits 0,10100101,1,0,00111100,1, each 4 clocks; o_done at clock 81 after load.
REQ-031 SHALL cover: parity enabled, PARITY_ODD=0, char 0xA5 -> parity bit 0; PARITY_ODD=1 -> parity bit 1; frame 11 bits.
REQ-032 SHALL cover: i_valid held high across o_done -> second burst starts the cycle after o_done; no missed or duplicated load.
REQ-033 SHALL cover: i_rst pulsed during bit 3 of character 1 -> o_tx = 1 and o_ready = 1 in the same cycle, no o_done.
REQ-034 SHALL cover: i_data changed and i_valid pulsed while o_busy -> transmitted bits unchanged, no second burst.
REQ-035 SHALL cover: DATA_BITS=5, STOP_BITS=2, WORDS=1, load 5'h13 -> bits 0,11001,1,1; total 32 clocks.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART transmitter types: FSM state encoding and line idle level.
// UART_TX_BURST_PARITY_EN adds the PARITY state to the encoding.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_TX_BURST_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } tx_state_e;

  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: o_tick marks the last clock of each BAUD_PRESCALER-long bit.
// Holds at zero while i_run is low, so every run starts a fresh bit period.
module uart_baud_tick #(
  parameter int unsigned BAUD_PRESCALER = 200
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_run,
  output logic o_tick
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_PRESCALER - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else if (!i_run || cnt_q == CNT_LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign o_tick = i_run && (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_tx_burst.sv
// Burst UART transmitter: captures WORDS characters on load and sends them back to back.
// Define UART_TX_BURST_PARITY_EN to append a parity bit (sense set by PARITY_ODD) to each character.
module uart_tx_burst
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_PRESCALER = 200,
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned WORDS          = 4,
  parameter int unsigned STOP_BITS      = 1,
  parameter int unsigned PARITY_ODD     = 0
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [WORDS*DATA_BITS-1:0] i_data,
  input  logic                       i_valid,
  output logic                       o_ready,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_tx
);

  localparam int unsigned PAY_W  = WORDS * DATA_BITS;
  localparam int unsigned BIT_W  = 4;
  localparam int unsigned WORD_W = 5;

  // Reject out-of-range configurations at elaboration.
  if (BAUD_PRESCALER < 2 || BAUD_PRESCALER > 65535) begin : g_bad_prescaler
    $error("uart_tx_burst: BAUD_PRESCALER out of range");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_burst: DATA_BITS out of range");
  end
  if (WORDS < 1 || WORDS > 16) begin : g_bad_words
    $error("uart_tx_burst: WORDS out of range");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_burst: STOP_BITS out of range");
  end
  if (PARITY_ODD > 1) begin : g_bad_parity_odd
    $error("uart_tx_burst: PARITY_ODD must be 0 or 1");
  end

  tx_state_e          state_q, state_d;
  logic [PAY_W-1:0]   shreg_q, shreg_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic               stop_q, stop_d;
  logic               tx_d, ready_d, busy_d, done_d;
  logic               tick, run, load;
`ifdef UART_TX_BURST_PARITY_EN
  logic               par_q, par_d;
`endif

  assign load = i_valid & o_ready;
  assign run  = (state_q != ST_IDLE);

  uart_baud_tick #(
    .BAUD_PRESCALER(BAUD_PRESCALER)
  ) u_baud_tick (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_run  (run),
    .o_tick (tick)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      bit_q   <= '0;
      word_q  <= '0;
      stop_q  <= 1'b0;
      o_tx    <= LINE_IDLE;
      o_ready <= 1'b1;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
`ifdef UART_TX_BURST_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      word_q  <= word_d;
      stop_q  <= stop_d;
      o_tx    <= tx_d;
      o_ready <= ready_d;
      o_busy  <= busy_d;
      o_done  <= done_d;
`ifdef UART_TX_BURST_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next state; the current data bit always sits in shreg[0].
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    word_d  = word_q;
    stop_d  = stop_q;
    done_d  = 1'b0;
`ifdef UART_TX_BURST_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          state_d = ST_START;
          shreg_d = i_data;
          word_d  = '0;
        end
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          bit_d   = '0;
`ifdef UART_TX_BURST_PARITY_EN
          par_d   = 1'b0;
`endif
        end
      end
      ST_DATA: begin
        if (tick) begin
          shreg_d = shreg_q >> 1;
`ifdef UART_TX_BURST_PARITY_EN
          par_d   = par_q ^ shreg_q[0];
`endif
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_BURST_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
            stop_d  = 1'b0;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
`ifdef UART_TX_BURST_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          state_d = ST_STOP;
          stop_d  = 1'b0;
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          if (stop_q == 1'(STOP_BITS - 1)) begin
            if (word_q == WORD_W'(WORDS - 1)) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_START;
              word_d  = word_q + WORD_W'(1);
            end
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Line level follows the next state so o_tx lines up with state_q.
    tx_d = LINE_IDLE;
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shreg_d[0];
`ifdef UART_TX_BURST_PARITY_EN
      ST_PARITY: tx_d = par_d ^ 1'(PARITY_ODD);
`endif
      default:   tx_d = LINE_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_uart_tx_burst.sv
// Randomized self-checking bench for uart_tx_burst against a bit-list frame model.
// Honours UART_TX_BURST_PARITY_EN in the model the same way the design does.
module tb_uart_tx_burst;

  localparam int unsigned BP = 4;
`ifdef UART_TX_BURST_PARITY_EN
  localparam int unsigned PB = 1;
`else
  localparam int unsigned PB = 0;
`endif

  logic i_clk = 1'b0;
  logic i_rst;
  always #5 i_clk = ~i_clk;

  logic [15:0] data_a;
  logic        valid_a, ready_a, busy_a, done_a, tx_a;
  logic [4:0]  data_b;
  logic        valid_b, ready_b, busy_b, done_b, tx_b;

  uart_tx_burst #(
    .BAUD_PRESCALER(BP), .DATA_BITS(8), .WORDS(2), .STOP_BITS(1), .PARITY_ODD(0)
  ) dut_a (
    .i_clk(i_clk), .i_rst(i_rst), .i_data(data_a), .i_valid(valid_a),
    .o_ready(ready_a), .o_busy(busy_a), .o_done(done_a), .o_tx(tx_a)
  );

  uart_tx_burst #(
    .BAUD_PRESCALER(BP), .DATA_BITS(5), .WORDS(1), .STOP_BITS(2), .PARITY_ODD(1)
  ) dut_b (
    .i_clk(i_clk), .i_rst(i_rst), .i_data(data_b), .i_valid(valid_b),
    .o_ready(ready_b), .o_busy(busy_b), .o_done(done_b), .o_tx(tx_b)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  bit          exp_bits[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Expected line bits of one burst, one entry per bit period.
  task automatic build_frame(input logic [63:0] data, input int db, input int words,
                             input int stops, input int podd);
    bit p;
    exp_bits.delete();
    for (int k = 0; k < words; k++) begin
      p = podd[0];
      exp_bits.push_back(1'b0);
      for (int b = 0; b < db; b++) begin
        exp_bits.push_back(data[k*db + b]);
        p = p ^ data[k*db + b];
      end
      if (PB == 1) exp_bits.push_back(p);
      for (int s = 0; s < stops; s++) exp_bits.push_back(1'b1);
    end
  endtask

  // {tx, ready, busy, done} of the selected instance.
  function automatic logic [3:0] outs(input bit sel);
    return sel ? {tx_b, ready_b, busy_b, done_b} : {tx_a, ready_a, busy_a, done_a};
  endfunction

  task automatic load(input bit sel, input logic [15:0] d);
    @(negedge i_clk);
    if (sel) begin data_b = d[4:0]; valid_b = 1'b1; end
    else     begin data_a = d;      valid_a = 1'b1; end
    @(posedge i_clk);
    #1;
    valid_a = 1'b0;
    valid_b = 1'b0;
  endtask

  // Checks ncyc cycles after a load (0 = whole frame); optionally disturbs dut_a inputs at chg_at.
  task automatic frame_check(input bit sel, input int ncyc, input bit want_done,
                             input int chg_at, input logic [15:0] chg_data, input bit hold);
    logic [3:0] o;
    int n;
    n = (ncyc == 0) ? exp_bits.size() * BP : ncyc;
    for (int c = 1; c <= n; c++) begin
      @(negedge i_clk);
      o = outs(sel);
      check($sformatf("tx c%0d", c), 32'(o[3]), 32'(exp_bits[(c-1)/BP]));
      if (c == 1 || c == n) begin
        check("busy_in_burst", 32'(o[1]), 32'd1);
        check("ready_in_burst", 32'(o[2]), 32'd0);
        check("done_in_burst", 32'(o[0]), 32'd0);
      end
      if (!sel && chg_at != 0 && c == chg_at) begin
        data_a  = chg_data;
        valid_a = 1'b1;
      end
      if (!sel && chg_at != 0 && c == chg_at + 1 && !hold) valid_a = 1'b0;
    end
    if (want_done) begin
      @(negedge i_clk);
      o = outs(sel);
      check("done_pulse", 32'(o[0]), 32'd1);
      check("ready_at_done", 32'(o[2]), 32'd1);
      check("busy_at_done", 32'(o[1]), 32'd0);
      check("tx_at_done", 32'(o[3]), 32'd1);
    end
  endtask

  task automatic idle_check(input bit sel, input int ncyc);
    logic [3:0] o;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge i_clk);
      o = outs(sel);
      check("idle_state", 32'(o), 32'b1100);
    end
  endtask

  logic [15:0] d1, d2;
  int          rst_cyc;

  initial begin
    i_rst = 1'b1; valid_a = 1'b0; valid_b = 1'b0; data_a = '0; data_b = '0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_a", 32'(outs(1'b0)), 32'b1100);
    check("rst_b", 32'(outs(1'b1)), 32'b1100);
    i_rst = 1'b0;
    idle_check(1'b0, 2);

    // Directed burst 0x3CA5: two characters, done one cycle after the frame.
    load(1'b0, 16'h3CA5);
    build_frame(64'h3CA5, 8, 2, 1, 0);
    frame_check(1'b0, 0, 1'b1, 0, 16'h0, 1'b0);
    idle_check(1'b0, 2);

    // Random bursts; payload changed and i_valid pulsed mid-burst must be ignored.
    for (int i = 0; i < 4; i++) begin
      d1 = 16'($urandom);
      d2 = 16'($urandom);
      repeat ($urandom_range(0, 3)) @(posedge i_clk);
      load(1'b0, d1);
      build_frame(64'(d1), 8, 2, 1, 0);
      frame_check(1'b0, 0, 1'b1, int'($urandom_range(2, 70)), d2, 1'b0);
      idle_check(1'b0, 2);
    end

    // Back-to-back: i_valid held through o_done loads the next payload once.
    d1 = 16'($urandom);
    d2 = 16'($urandom);
    @(negedge i_clk);
    data_a = d1; valid_a = 1'b1;
    @(posedge i_clk);
    build_frame(64'(d1), 8, 2, 1, 0);
    frame_check(1'b0, 0, 1'b1, 30, d2, 1'b1);
    @(posedge i_clk);
    #1 valid_a = 1'b0;
    build_frame(64'(d2), 8, 2, 1, 0);
    frame_check(1'b0, 0, 1'b1, 0, 16'h0, 1'b0);
    idle_check(1'b0, 3);

    // Reset during data bit 3 of character 1 (that bit forced low).
    d1 = 16'($urandom) & 16'hF7FF;
    rst_cyc = int'((1 + 8 + PB + 1 + 4) * BP + 2);
    load(1'b0, d1);
    build_frame(64'(d1), 8, 2, 1, 0);
    frame_check(1'b0, rst_cyc - 1, 1'b0, 0, 16'h0, 1'b0);
    @(negedge i_clk);
    check("tx_before_rst", 32'(tx_a), 32'd0);
    i_rst = 1'b1;
    #1;
    check("rst_mid_burst", 32'(outs(1'b0)), 32'b1100);
    @(negedge i_clk);
    i_rst = 1'b0;
    idle_check(1'b0, 50);

    // Recovery after abort.
    d1 = 16'($urandom);
    load(1'b0, d1);
    build_frame(64'(d1), 8, 2, 1, 0);
    frame_check(1'b0, 0, 1'b1, 0, 16'h0, 1'b0);

    // Five data bits, two stop bits, single character.
    load(1'b1, 16'h0013);
    build_frame(64'h13, 5, 1, 2, 1);
    check("frame_len_b", 32'(exp_bits.size() * BP), 32'((8 + PB) * BP));
    frame_check(1'b1, 0, 1'b1, 0, 16'h0, 1'b0);
    idle_check(1'b1, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
